// File: rtl/bcd_timer_pkg.sv
// Shared BCD constants and helpers for the bcd_timer block.
package bcd_timer_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    // Out-of-range BCD codes (A..F) are treated as 9.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_timer_digit.sv
// One BCD digit register with inc/dec, carry/borrow chaining and clamped preset load.
module bcd_timer_digit
    import bcd_timer_pkg::*;
(
    input  logic             clk,
    input  logic             init_regs,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    input  logic             step_in,
    input  logic             count_down,
    output logic [BCD_W-1:0] digit,
    output logic             at_max,
    output logic             at_zero,
    output logic             step_out
);

    logic [BCD_W-1:0] digit_q, digit_d;
    dir_e             dir;

    assign dir = dir_e'(count_down);

    assign at_max  = (digit_q == BCD_MAX);
    assign at_zero = (digit_q == BCD_ZERO);

    // Carry (up) or borrow (down) ripples to the next digit when this one wraps.
    assign step_out = step_in & ((dir == DirDown) ? at_zero : at_max);

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_clamp(load_digit);
        end else if (step_in) begin
            if (dir == DirDown) begin
                digit_d = at_zero ? BCD_MAX : (digit_q - 4'd1);
            end else begin
                digit_d = at_max ? BCD_ZERO : (digit_q + 4'd1);
            end
        end
    end

    always_ff @(posedge clk or posedge init_regs) begin
        if (init_regs) begin
            digit_q <= BCD_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/bcd_timer.sv
// Parametrised BCD seconds timer: prescaler, DIGITS-wide up/down BCD counter,
// wrap/saturate limits, preset load and lap-freeze of the displayed reading.
module bcd_timer
    import bcd_timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned WRAP     = 1
) (
    input  logic                    clk,
    input  logic                    init_regs,
    input  logic                    count_enabled,
    input  logic                    count_down,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_value,
    input  logic                    lap,
    output logic [BCD_W*DIGITS-1:0] time_reading,
    output logic                    frozen,
    output logic                    tick,
    output logic                    terminal
);

    localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLK_FREQ - 1);
    localparam int unsigned VW = BCD_W * DIGITS;

    logic [PW-1:0]   presc_q, presc_d;
    logic [VW-1:0]   value;
    logic [VW-1:0]   snap_q, snap_d;
    logic            frozen_q, frozen_d;
    logic            tick_q, tick_d;
    logic            term_q, term_d;

    logic [DIGITS:0]   carry;
    logic [DIGITS-1:0] dig_max, dig_zero;
    logic              step, sat_hold;
    logic              all_max, all_zero;
    logic              upper_max, upper_zero;
    logic              reach_limit;

    assign step     = count_enabled && !load && (presc_q == P_LAST);
    assign all_max  = &dig_max;
    assign all_zero = &dig_zero;
    assign sat_hold = (WRAP == 0) && (count_down ? all_zero : all_max);

    // A saturated step still ticks but must not ripple through the digits.
    assign carry[0] = step && !sat_hold;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_timer_digit u_digit (
            .clk        (clk),
            .init_regs  (init_regs),
            .load       (load),
            .load_digit (load_value[g*BCD_W +: BCD_W]),
            .step_in    (carry[g]),
            .count_down (count_down),
            .digit      (value[g*BCD_W +: BCD_W]),
            .at_max     (dig_max[g]),
            .at_zero    (dig_zero[g]),
            .step_out   (carry[g+1])
        );
    end

    // Saturating mode flags terminal only on the step that lands on the limit.
    always_comb begin
        upper_max  = 1'b1;
        upper_zero = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            upper_max  = upper_max & dig_max[i];
            upper_zero = upper_zero & dig_zero[i];
        end
        if (count_down) begin
            reach_limit = upper_zero && (value[BCD_W-1:0] == 4'd1);
        end else begin
            reach_limit = upper_max && (value[BCD_W-1:0] == 4'd8);
        end
    end

    always_comb begin
        presc_d  = presc_q;
        snap_d   = snap_q;
        frozen_d = frozen_q;
        tick_d   = step;
        term_d   = 1'b0;

        if (step) begin
            if (WRAP != 0) begin
                term_d = count_down ? all_zero : all_max;
            end else begin
                term_d = reach_limit;
            end
        end

        if (load) begin
            presc_d  = '0;
            frozen_d = 1'b0;
        end else begin
            if (count_enabled) begin
                presc_d = step ? '0 : (presc_q + 1'b1);
            end
            if (lap) begin
                frozen_d = !frozen_q;
                if (!frozen_q) begin
                    snap_d = value;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge init_regs) begin
        if (init_regs) begin
            presc_q  <= '0;
            snap_q   <= '0;
            frozen_q <= 1'b0;
            tick_q   <= 1'b0;
            term_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            snap_q   <= snap_d;
            frozen_q <= frozen_d;
            tick_q   <= tick_d;
            term_q   <= term_d;
        end
    end

    assign time_reading = frozen_q ? snap_q : value;
    assign frozen       = frozen_q;
    assign tick         = tick_q;
    assign terminal     = term_q;

endmodule

// File: tb/tb_bcd_timer.sv
// Self-checking bench for bcd_timer: a wrapping and a saturating instance share
// stimulus and are compared each cycle against an integer-arithmetic seconds model.
module tb_bcd_timer;

    logic       clk = 1'b0;
    logic       init_regs;
    logic       count_enabled;
    logic       count_down;
    logic       load;
    logic [7:0] load_value;
    logic       lap;

    logic [7:0] rd0, rd1;
    logic       fr0, fr1, tk0, tk1, tm0, tm1;

    wire [10:0] obs0 = {rd0, fr0, tk0, tm0};
    wire [10:0] obs1 = {rd1, fr1, tk1, tm1};

    int n_checks = 0;
    int n_pass   = 0;

    // Model state, index 0 = saturating instance, 1 = wrapping instance.
    int m_val[2];
    int m_snap[2];
    int m_ph[2];
    bit m_fr[2];
    bit m_tk[2];
    bit m_tm[2];

    always #5 clk = ~clk;

    bcd_timer #(.CLK_FREQ(10), .DIGITS(2), .WRAP(0)) u_dut_sat (
        .clk           (clk),
        .init_regs     (init_regs),
        .count_enabled (count_enabled),
        .count_down    (count_down),
        .load          (load),
        .load_value    (load_value),
        .lap           (lap),
        .time_reading  (rd0),
        .frozen        (fr0),
        .tick          (tk0),
        .terminal      (tm0)
    );

    bcd_timer #(.CLK_FREQ(10), .DIGITS(2), .WRAP(1)) u_dut_wrap (
        .clk           (clk),
        .init_regs     (init_regs),
        .count_enabled (count_enabled),
        .count_down    (count_down),
        .load          (load),
        .load_value    (load_value),
        .lap           (lap),
        .time_reading  (rd1),
        .frozen        (fr1),
        .tick          (tk1),
        .terminal      (tm1)
    );

    function automatic void model_reset();
        for (int w = 0; w < 2; w++) begin
            m_val[w] = 0; m_snap[w] = 0; m_ph[w] = 0;
            m_fr[w] = 0; m_tk[w] = 0; m_tm[w] = 0;
        end
    endfunction

    function automatic logic [10:0] exp_vec(int w);
        int r;
        r = m_fr[w] ? m_snap[w] : m_val[w];
        return {4'(r / 10), 4'(r % 10), m_fr[w], m_tk[w], m_tm[w]};
    endfunction

    function automatic logic [10:0] obs_vec(int w);
        return (w == 0) ? obs0 : obs1;
    endfunction

    // Advance one clock; the model consumes the inputs held across the edge.
    task automatic clk_cycle();
        int hi, lo;
        @(posedge clk);
        for (int w = 0; w < 2; w++) begin
            m_tk[w] = 0;
            m_tm[w] = 0;
            if (load) begin
                hi = (load_value[7:4] > 9) ? 9 : int'(load_value[7:4]);
                lo = (load_value[3:0] > 9) ? 9 : int'(load_value[3:0]);
                m_val[w] = hi * 10 + lo;
                m_ph[w]  = 0;
                m_fr[w]  = 0;
            end else begin
                if (lap) begin
                    if (!m_fr[w]) m_snap[w] = m_val[w];
                    m_fr[w] = !m_fr[w];
                end
                if (count_enabled) begin
                    if (m_ph[w] == 9) begin
                        m_ph[w] = 0;
                        m_tk[w] = 1;
                        if (!count_down) begin
                            if (m_val[w] == 99) begin
                                if (w == 1) begin m_val[w] = 0; m_tm[w] = 1; end
                            end else begin
                                m_val[w] = m_val[w] + 1;
                                if (w == 0 && m_val[w] == 99) m_tm[w] = 1;
                            end
                        end else begin
                            if (m_val[w] == 0) begin
                                if (w == 1) begin m_val[w] = 99; m_tm[w] = 1; end
                            end else begin
                                m_val[w] = m_val[w] - 1;
                                if (w == 0 && m_val[w] == 0) m_tm[w] = 1;
                            end
                        end
                    end else begin
                        m_ph[w] = m_ph[w] + 1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int w = 0; w < 2; w++) begin
            n_checks++;
            if (obs_vec(w) !== exp_vec(w))
                $display("FAIL reset w%0d: got %h want %h", w, obs_vec(w), exp_vec(w));
            else n_pass++;
        end
    endtask

    task automatic test_up_count();
        int ticks = 0;
        count_enabled = 1; count_down = 0;
        for (int i = 0; i < 25; i++) begin
            clk_cycle();
            if (tk1) ticks++;
            for (int w = 0; w < 2; w++) begin
                n_checks++;
                if (obs_vec(w) !== exp_vec(w))
                    $display("FAIL up_count w%0d cyc%0d: got %h want %h",
                             w, i, obs_vec(w), exp_vec(w));
                else n_pass++;
            end
        end
        n_checks++;
        if (ticks !== 2) $display("FAIL up_tick_count: got %0d want 2", ticks);
        else n_pass++;
    endtask

    task automatic test_wrap_up();
        count_down = 0;
        for (int i = 0; i < 28; i++) begin
            load       = (i == 0) || (i == 26);
            load_value = (i == 26) ? 8'hAF : 8'h98;
            clk_cycle();
            load = 0;
            for (int w = 0; w < 2; w++) begin
                n_checks++;
                if (obs_vec(w) !== exp_vec(w))
                    $display("FAIL wrap_up w%0d cyc%0d: got %h want %h",
                             w, i, obs_vec(w), exp_vec(w));
                else n_pass++;
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 56; i++) begin
            load       = (i == 0);
            load_value = 8'h98;
            count_down = (i > 40);
            clk_cycle();
            load = 0;
            for (int w = 0; w < 2; w++) begin
                n_checks++;
                if (obs_vec(w) !== exp_vec(w))
                    $display("FAIL saturate w%0d cyc%0d: got %h want %h",
                             w, i, obs_vec(w), exp_vec(w));
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap_down();
        count_down = 1;
        for (int i = 0; i < 35; i++) begin
            load       = (i == 0);
            load_value = 8'h01;
            clk_cycle();
            load = 0;
            for (int w = 0; w < 2; w++) begin
                n_checks++;
                if (obs_vec(w) !== exp_vec(w))
                    $display("FAIL wrap_down w%0d cyc%0d: got %h want %h",
                             w, i, obs_vec(w), exp_vec(w));
                else n_pass++;
            end
        end
        count_down = 0;
    endtask

    task automatic test_lap();
        for (int i = 0; i < 86; i++) begin
            load       = (i == 0) || (i == 80);
            load_value = (i == 80) ? 8'h42 : 8'h00;
            lap        = (i == 31) || (i == 61) || (i == 80);
            clk_cycle();
            load = 0; lap = 0;
            for (int w = 0; w < 2; w++) begin
                n_checks++;
                if (obs_vec(w) !== exp_vec(w))
                    $display("FAIL lap w%0d cyc%0d: got %h want %h",
                             w, i, obs_vec(w), exp_vec(w));
                else n_pass++;
            end
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 72; i++) begin
            load          = (i == 0);
            load_value    = 8'h10;
            count_enabled = !(i >= 5 && i < 60);
            clk_cycle();
            load = 0;
            for (int w = 0; w < 2; w++) begin
                n_checks++;
                if (obs_vec(w) !== exp_vec(w))
                    $display("FAIL enable w%0d cyc%0d: got %h want %h",
                             w, i, obs_vec(w), exp_vec(w));
                else n_pass++;
            end
        end
        count_enabled = 1;
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            clk_cycle();
            seen = m_tk[1];
            for (int w = 0; w < 2; w++) begin
                n_checks++;
                if (obs_vec(w) !== exp_vec(w))
                    $display("FAIL pre_reset w%0d cyc%0d: got %h want %h",
                             w, i, obs_vec(w), exp_vec(w));
                else n_pass++;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL pre_reset_tick: got no tick within 20 cycles want one");
        else n_pass++;
        // Assert reset between edges; outputs must clear without a clock edge.
        #2 init_regs = 1;
        #1;
        model_reset();
        for (int w = 0; w < 2; w++) begin
            n_checks++;
            if (obs_vec(w) !== exp_vec(w))
                $display("FAIL async_reset w%0d: got %h want %h", w, obs_vec(w), exp_vec(w));
            else n_pass++;
        end
        #2 init_regs = 0;
        for (int i = 0; i < 12; i++) begin
            clk_cycle();
            for (int w = 0; w < 2; w++) begin
                n_checks++;
                if (obs_vec(w) !== exp_vec(w))
                    $display("FAIL post_reset w%0d cyc%0d: got %h want %h",
                             w, i, obs_vec(w), exp_vec(w));
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            count_enabled = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) count_down = !count_down;
            load       = ($urandom_range(0, 59) == 0);
            load_value = 8'($urandom);
            lap        = ($urandom_range(0, 24) == 0);
            clk_cycle();
            load = 0; lap = 0;
            for (int w = 0; w < 2; w++) begin
                n_checks++;
                if (obs_vec(w) !== exp_vec(w))
                    $display("FAIL random w%0d cyc%0d: got %h want %h",
                             w, i, obs_vec(w), exp_vec(w));
                else n_pass++;
            end
        end
    endtask

    initial begin
        init_regs     = 1;
        count_enabled = 1;
        count_down    = 0;
        load          = 0;
        load_value    = 8'h00;
        lap           = 0;
        model_reset();
        #20 init_regs = 0;
        test_reset();
        test_up_count();
        test_wrap_up();
        test_saturate();
        test_wrap_down();
        test_lap();
        test_enable();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
